// File: rtl/snn_stream_pkg.sv
// Shared types for the spike frame streamer: FSM state encoding, event record, width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snn_stream_pkg;

    // Streamer FSM states; the top maps these onto plain 3-bit constants.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_WAIT_DATA  = 3'd2,
        ST_SCAN       = 3'd3,
        ST_TS_END     = 3'd4,
        ST_WAIT_LAYER = 3'd5,
        ST_DONE       = 3'd6
    } stream_state_e;

    // Widest coordinate any instance is expected to carry.
    localparam int EVT_FIELD_W = 16;

    // One spike event: time step, channel, row, column.
    typedef struct packed {
        logic [EVT_FIELD_W-1:0] ts;
        logic [EVT_FIELD_W-1:0] ch;
        logic [EVT_FIELD_W-1:0] row;
        logic [EVT_FIELD_W-1:0] col;
    } spike_evt_t;

    // clog2 that never collapses to a zero-width field.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_prio_enc.sv
// Lowest-set-bit priority encoder: index of the least significant 1, plus an any flag.
// Latency: purely combinational.
// Backpressure: none; index is 0 when no bit is set.
module spike_prio_enc
    import snn_stream_pkg::*;
#(
    parameter int WIDTH = 64,
    localparam int IDX_W = clog2_min1(WIDTH)
) (
    input  logic [WIDTH-1:0] bits,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    // Scan from the top down so the last hit (lowest bit) wins.
    always_comb begin
        index = '0;
        any   = |bits;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (bits[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/spike_frame_streamer.sv
// Streams spike frames row by row from memory as (ts, ch, row, col) events, one step per layer ack.
// Latency: 2 cycles from row fetch to first event, then 1 event/cycle, 1 idle cycle per row.
// Backpressure: evt_ready low freezes the current event; layer_avail gates each next time step.
module spike_frame_streamer
    import snn_stream_pkg::*;
#(
    parameter int INPUT_CHANNELS    = 2,
    parameter int INPUT_FRAME_WIDTH = 64,
    parameter int TIME_STEPS        = 4,
    localparam int AW    = clog2_min1(TIME_STEPS * INPUT_CHANNELS * INPUT_FRAME_WIDTH),
    localparam int TS_W  = clog2_min1(TIME_STEPS),
    localparam int CH_W  = clog2_min1(INPUT_CHANNELS),
    localparam int POS_W = clog2_min1(INPUT_FRAME_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         input_avail,
    output logic                         mem_rd_en,
    output logic [AW-1:0]                mem_addr,
    input  logic [INPUT_FRAME_WIDTH-1:0] mem_rd_data,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [TS_W-1:0]              evt_ts,
    output logic [CH_W-1:0]              evt_ch,
    output logic [POS_W-1:0]             evt_row,
    output logic [POS_W-1:0]             evt_col,
    output logic                         ts_end,
    input  logic                         layer_avail,
    output logic                         busy,
    output logic                         done
);

    localparam logic [2:0] IDLE       = ST_IDLE;
    localparam logic [2:0] FETCH      = ST_FETCH;
    localparam logic [2:0] WAIT_DATA  = ST_WAIT_DATA;
    localparam logic [2:0] SCAN       = ST_SCAN;
    localparam logic [2:0] TS_END     = ST_TS_END;
    localparam logic [2:0] WAIT_LAYER = ST_WAIT_LAYER;
    localparam logic [2:0] DONE       = ST_DONE;

    localparam int ROW_STRIDE = INPUT_FRAME_WIDTH;
    localparam int TS_STRIDE  = INPUT_CHANNELS * INPUT_FRAME_WIDTH;

    logic [2:0]                   state_q, state_d;
    logic [TS_W-1:0]              ts_q, ts_d;
    logic [CH_W-1:0]              ch_q, ch_d;
    logic [POS_W-1:0]             row_q, row_d;
    logic [INPUT_FRAME_WIDTH-1:0] row_bits_q, row_bits_d;

    logic [POS_W-1:0] lsb_idx;
    logic             lsb_any;
    logic             last_row;
    logic             last_ch;
    logic             last_ts;

    spike_prio_enc #(
        .WIDTH (INPUT_FRAME_WIDTH)
    ) u_prio (
        .bits  (row_bits_q),
        .index (lsb_idx),
        .any   (lsb_any)
    );

    assign last_row = (row_q == POS_W'(INPUT_FRAME_WIDTH - 1));
    assign last_ch  = (ch_q  == CH_W'(INPUT_CHANNELS - 1));
    assign last_ts  = (ts_q  == TS_W'(TIME_STEPS - 1));

    // Next-state, counter and row-register update for the fetch/scan/handshake sequence.
    always_comb begin
        state_d    = state_q;
        ts_d       = ts_q;
        ch_d       = ch_q;
        row_d      = row_q;
        row_bits_d = row_bits_q;
        case (state_q)
            IDLE: begin
                if (input_avail) begin
                    ts_d       = '0;
                    ch_d       = '0;
                    row_d      = '0;
                    row_bits_d = '0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                row_bits_d = mem_rd_data;
                state_d    = SCAN;
            end
            SCAN: begin
                if (lsb_any) begin
                    // x & (x-1) drops exactly the lowest set bit, i.e. the one just accepted.
                    if (evt_ready) begin
                        row_bits_d = row_bits_q & (row_bits_q - INPUT_FRAME_WIDTH'(1));
                    end
                end else if (last_row) begin
                    row_d = '0;
                    if (last_ch) begin
                        ch_d    = '0;
                        state_d = TS_END;
                    end else begin
                        ch_d    = ch_q + CH_W'(1);
                        state_d = FETCH;
                    end
                end else begin
                    row_d   = row_q + POS_W'(1);
                    state_d = FETCH;
                end
            end
            TS_END: begin
                state_d = WAIT_LAYER;
            end
            WAIT_LAYER: begin
                if (layer_avail) begin
                    if (last_ts) begin
                        state_d = DONE;
                    end else begin
                        ts_d    = ts_q + TS_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ts_q       <= '0;
            ch_q       <= '0;
            row_q      <= '0;
            row_bits_q <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            ch_q       <= ch_d;
            row_q      <= row_d;
            row_bits_q <= row_bits_d;
        end
    end

    // Outputs decode straight from registered state, so they hold while evt_ready is low.
    always_comb begin
        mem_rd_en = (state_q == FETCH);
        mem_addr  = AW'(int'(ts_q) * TS_STRIDE + int'(ch_q) * ROW_STRIDE + int'(row_q));
        evt_valid = (state_q == SCAN) && lsb_any;
        evt_ts    = ts_q;
        evt_ch    = ch_q;
        evt_row   = row_q;
        evt_col   = lsb_idx;
        ts_end    = (state_q == TS_END);
        done      = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_spike_frame_streamer.sv
// Randomized bench for spike_frame_streamer with an event-list reference model.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Layer acknowledgement is issued 3 cycles after each ts_end unless withheld.
module tb_spike_frame_streamer;
    import snn_stream_pkg::*;

    localparam int CH = 2;
    localparam int W  = 64;
    localparam int T  = 4;
    localparam int NROWS = T * CH * W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        input_avail = 1'b0;
    logic        mem_rd_en;
    logic [8:0]  mem_addr;
    logic [63:0] mem_rd_data = '0;
    logic        evt_valid;
    logic        evt_ready = 1'b1;
    logic [1:0]  evt_ts;
    logic [0:0]  evt_ch;
    logic [5:0]  evt_row;
    logic [5:0]  evt_col;
    logic        ts_end;
    logic        layer_avail = 1'b0;
    logic        busy;
    logic        done;

    spike_frame_streamer #(
        .INPUT_CHANNELS    (CH),
        .INPUT_FRAME_WIDTH (W),
        .TIME_STEPS        (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .input_avail (input_avail),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_ts      (evt_ts),
        .evt_ch      (evt_ch),
        .evt_row     (evt_row),
        .evt_col     (evt_col),
        .ts_end      (ts_end),
        .layer_avail (layer_avail),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Frame memory with one-cycle registered read.
    logic [63:0] mem [0:NROWS-1];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    int total = 0;
    int bad   = 0;
    int cyc = 0, ts_end_cnt = 0, done_cnt = 0, vld_cycles = 0, rd_cnt = 0;
    int hold_chks = 0, stall_left = 0, lay_cnt = 0, ts2_hs = 0, rmode = 0;
    bit auto_ack = 1'b1, rst_plan = 1'b0, rst_fired = 1'b0, prev_stall = 1'b0;
    logic [63:0] prev_bus = '0;
    spike_evt_t  exp_q[$];
    logic [63:0] obs_q[$];
    int          hs_cyc[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    function automatic logic [63:0] key(input int t, input int c, input int r, input int col);
        return {16'(t), 16'(c), 16'(r), 16'(col)};
    endfunction

    function automatic logic [63:0] outs_packed();
        return 64'({mem_rd_en, mem_addr, evt_valid, evt_ts, evt_ch, evt_row, evt_col,
                    ts_end, done, busy});
    endfunction

    // Expected events straight from the frame contents: ts, channel, row, then ascending column.
    task automatic build_exp();
        exp_q.delete();
        for (int t = 0; t < T; t++)
            for (int c = 0; c < CH; c++)
                for (int r = 0; r < W; r++)
                    for (int col = 0; col < W; col++)
                        if (mem[t*CH*W + c*W + r][col])
                            exp_q.push_back('{ts: 16'(t), ch: 16'(c), row: 16'(r), col: 16'(col)});
    endtask

    task automatic clear_mem();
        for (int i = 0; i < NROWS; i++) mem[i] = '0;
    endtask

    // Sparse random frames; ts0 ch0 row0 always carries a spike.
    task automatic fill_random();
        for (int i = 0; i < NROWS; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ?
                     ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom}) : 64'd0;
        mem[0][3] = 1'b1;
    endtask

    task automatic reset_counters();
        ts_end_cnt = 0; done_cnt = 0; vld_cycles = 0; rd_cnt = 0;
        hold_chks = 0; lay_cnt = 0; ts2_hs = 0;
        hs_cyc.delete(); obs_q.delete();
    endtask

    // One clock: observe outputs, drive inputs for the next edge, score any handshake.
    task automatic tick();
        logic [63:0] bus_now;
        spike_evt_t  e;
        @(negedge clk);
        cyc++;
        bus_now = 64'({evt_valid, evt_ts, evt_ch, evt_row, evt_col});
        if (prev_stall) begin
            hold_chks++;
            chk("evt_hold", bus_now, prev_bus);
        end
        if (ts_end)    ts_end_cnt++;
        if (done)      done_cnt++;
        if (evt_valid) vld_cycles++;
        if (mem_rd_en) rd_cnt++;

        case (rmode)
            0: evt_ready = 1'b1;
            1: evt_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (evt_valid && stall_left > 0) begin
                    evt_ready = 1'b0;
                    stall_left--;
                end else begin
                    evt_ready = 1'b1;
                end
            end
        endcase

        layer_avail = 1'b0;
        if (lay_cnt > 0) begin
            lay_cnt--;
            if (lay_cnt == 0) layer_avail = 1'b1;
        end
        if (ts_end && auto_ack) lay_cnt = 3;

        if (rst_plan && evt_valid && evt_ts == 2'd2 && ts2_hs == 2) begin
            rst = 1'b1;
            rst_plan = 1'b0;
            rst_fired = 1'b1;
            lay_cnt = 0;
        end else if (evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_evt", key(evt_ts, evt_ch, evt_row, evt_col), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("evt", key(evt_ts, evt_ch, evt_row, evt_col), key(e.ts, e.ch, e.row, e.col));
            end
            hs_cyc.push_back(cyc);
            obs_q.push_back(key(evt_ts, evt_ch, evt_row, evt_col));
            if (evt_ts == 2'd2) ts2_hs++;
        end
        prev_stall = evt_valid && !evt_ready && !rst;
        prev_bus   = bus_now;
    endtask

    task automatic start();
        input_avail = 1'b1;
        tick();
        input_avail = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, done_cnt, 1);
        repeat (20) tick();
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_ts_end_cnt"}, ts_end_cnt, T);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_leftover"}, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int vld_before;
        clear_mem();

        // Reset state.
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_outs", outs_packed(), 64'd0);
        rst = 1'b0;
        repeat (2) tick();
        chk("idle_outs", outs_packed(), 64'd0);

        // All-zero frames: no events, four ts_end pulses, one done, every row fetched once.
        reset_counters(); build_exp(); rmode = 0; auto_ack = 1'b1;
        start();
        run_until_done("zero", 8000);
        chk("zero_no_events", vld_cycles, 0);
        chk("zero_rows_read", rd_cnt, NROWS);

        // Bits 0 and 63 of ts0 ch1 row5: two events on back-to-back cycles.
        clear_mem();
        mem[0*CH*W + 1*W + 5] = 64'h8000_0000_0000_0001;
        reset_counters(); build_exp(); rmode = 0;
        start();
        run_until_done("edge", 8000);
        chk("edge_count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            chk("edge_first", obs_q[0], key(0, 1, 5, 0));
            chk("edge_second", obs_q[1], key(0, 1, 5, 63));
            chk("edge_b2b", hs_cyc[1] - hs_cyc[0], 1);
        end

        // Ten-cycle stall on the first event, random frames.
        fill_random();
        reset_counters(); build_exp(); rmode = 2; stall_left = 10;
        start();
        run_until_done("stall", 10000);
        chk("stall_holds", hold_chks, 10);

        // layer_avail during SCAN is ignored; withheld ack parks the FSM with no fetches.
        fill_random();
        reset_counters(); build_exp(); rmode = 0; auto_ack = 1'b0;
        start();
        n = 0;
        while (vld_cycles == 0 && n < 2000) begin tick(); n++; end
        chk("layer_scan_seen", vld_cycles > 0, 1);
        layer_avail = 1'b1;
        n = 0;
        while (ts_end_cnt == 0 && n < 4000) begin tick(); n++; end
        chk("layer_ts_end", ts_end_cnt, 1);
        n = rd_cnt;
        repeat (30) tick();
        chk("layer_no_fetch", rd_cnt, n);
        chk("layer_busy", busy, 1);
        chk("layer_no_ts_end", ts_end_cnt, 1);
        auto_ack = 1'b1;
        layer_avail = 1'b1;
        run_until_done("layer", 10000);

        // Reset on the third event of ts2, then a clean restart from ts0.
        fill_random();
        mem[2*CH*W] = mem[2*CH*W] | 64'h7;
        reset_counters(); build_exp(); rmode = 1; rst_plan = 1'b1; rst_fired = 1'b0;
        start();
        n = 0;
        while (!rst_fired && n < 10000) begin tick(); n++; end
        chk("rst_fired", rst_fired, 1);
        tick();
        chk("rst_outs_zero", outs_packed(), 64'd0);
        rst = 1'b0;
        rst_plan = 1'b0;
        vld_before = vld_cycles;
        repeat (20) tick();
        chk("rst_no_events", vld_cycles, vld_before);
        reset_counters(); build_exp();
        start();
        run_until_done("restart", 10000);
        chk("restart_has_events", obs_q.size() > 0, 1);
        if (obs_q.size() > 0) chk("restart_ts0", obs_q[0][63:48], 0);

        // input_avail held for 400 ns: a single inference.
        fill_random();
        reset_counters(); build_exp(); rmode = 1;
        input_avail = 1'b1;
        repeat (40) tick();
        input_avail = 1'b0;
        run_until_done("hold", 10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spike_frame_streamer.md
SPIKE_FRAME_STREAMER -- requirements
Module: spike_frame_streamer

Interface
REQ-001 The module SHALL have parameter INPUT_CHANNELS, default 2, meaning spike input channels per frame.
REQ-002 The module SHALL have parameter INPUT_FRAME_WIDTH, default 64, meaning frame rows and columns (square frame).
REQ-003 The module SHALL have parameter TIME_STEPS, default 4, meaning frames per inference.
REQ-004 The module SHALL have one clock; reset is synchronous and active-high; the ports are named clk and rst.
REQ-005 The module SHALL have port clk  input  1  the single clock.
REQ-006 The module SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 The module SHALL have port input_avail  input  1  start request, sampled only in IDLE.
REQ-008 The module SHALL have port mem_rd_en  output  1  frame-memory row read strobe.
REQ-009 The module SHALL have port mem_addr  output  AW  row address, AW = clog2(TIME_STEPS*INPUT_CHANNELS*INPUT_FRAME_WIDTH).
REQ-010 The module SHALL have port mem_rd_data  input  INPUT_FRAME_WIDTH  row bitmap, bit c = spike at column c, valid 1 cycle after mem_rd_en.
REQ-011 The module SHALL have ports evt_valid  output  1, and evt_ready  input  1, forming the spike-event handshake.
REQ-012 The module SHALL have ports evt_ts, evt_ch, evt_row and evt_col  output  clog2 widths (min 1)  event coordinates.
REQ-013 The module SHALL have port ts_end  output  1  one-cycle pulse when a time step has been fully emitted.
REQ-014 The module SHALL have port layer_avail  input  1  pulse from the conv layer meaning the time step has been consumed.
REQ-015 The module SHALL have ports busy  output  1, and done  output  1, where done is a one-cycle pulse after the last time step is acknowledged.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, WAIT_DATA, SCAN, TS_END, WAIT_LAYER and DONE.
REQ-017 In IDLE, input_avail=1 SHALL clear the ts/ch/row counters and move the FSM to FETCH; input_avail is ignored in all other states.
REQ-018 FETCH SHALL assert mem_rd_en for exactly one cycle with mem_addr = ts*CH*W + ch*W + row, then go to WAIT_DATA.
REQ-019 WAIT_DATA SHALL capture mem_rd_data into a row shift register and go to SCAN.
REQ-020 SCAN SHALL present the lowest set bit of the row register as an event (evt_col = bit index) with evt_valid=1.
REQ-021 On evt_valid & evt_ready, the emitted bit SHALL be cleared; the next event is presented on the following cycle, giving a sustained rate of 1 event/cycle.
REQ-022 While evt_valid=1 and evt_ready=0, all evt_* outputs SHALL hold stable.
REQ-023 When the row register is empty (including an all-zero row), evt_valid SHALL be 0 and the counters SHALL advance in row-major order within channel (col → row → channel); the FSM goes to FETCH, or to TS_END after the last row of the last channel.
REQ-024 TS_END SHALL pulse ts_end for one cycle, then go to WAIT_LAYER.
REQ-025 WAIT_LAYER SHALL wait for layer_avail=1; layer_avail is ignored in every other state.
REQ-026 On layer_avail, the FSM SHALL increment ts and go to FETCH, or go to DONE if ts = TIME_STEPS-1.
REQ-027 DONE SHALL pulse done for one cycle and then return to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.

Reset
REQ-029 rst SHALL force the FSM to IDLE, clear all counters and the row register, and drive mem_rd_en=0, evt_valid=0, ts_end=0, done=0, busy=0 and all evt_* coordinates to 0 on the next clock edge.
REQ-030 An rst asserted mid-operation (including mid-handshake) SHALL abort the transfer with no further events emitted; the next input_avail restarts from ts=0.

Structure
REQ-031 Package snn_stream_pkg SHALL hold the FSM state enum and a spike-event struct {ts, ch, row, col}.
REQ-032 Lowest-set-bit detection SHALL be a sub-module spike_prio_enc (parameter WIDTH; outputs index and any).

Verification
REQ-033 The bench SHALL cover: defaults with the memory all zeros, input_avail pulse -> 0 events, 4 ts_end pulses (each acknowledged by a layer_avail 3 cycles later), 1 done pulse.
REQ-034 The bench SHALL cover: ts0 ch1 row5 = 0x8000_0000_0000_0001 with evt_ready=1 -> events (0,1,5,0) then (0,1,5,63) on consecutive cycles.
REQ-035 The bench SHALL cover: evt_ready held 0 for 10 cycles during the first event -> evt_* stable, and no event is lost or duplicated.
REQ-036 The bench SHALL cover: layer_avail pulsed during SCAN and then withheld -> the FSM stalls in WAIT_LAYER and mem_rd_en stays 0.
REQ-037 The bench SHALL cover: rst asserted on the 3rd event of ts2 -> all outputs are 0 on the next cycle; a later input_avail restarts with evt_ts=0.
REQ-038 The bench SHALL cover: input_avail held high for 400 ns -> exactly one inference, with done asserted once.
